vr_rr_arbiter: RTL and testbench

- N-to-1 round-robin arbiter for valid/ready streams.
- Merges NUM_REQ upstream handshake channels onto one downstream channel through a single registered output stage.
- Sits in front of a shared datapath node chain, so several producers can share one node pipeline fairly.
- Full throughput: one beat per cycle when downstream is ready; one cycle latency.

---
 rtl/vr_arb_pkg.sv | 14 +
 rtl/vr_rr_arbiter_rr_pick.sv | 33 +++
 rtl/vr_rr_arbiter.sv | 134 +++++++++++++
 tb/tb_vr_rr_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/vr_arb_pkg.sv
// Shared types and helpers for the valid/ready round-robin arbiter family.
package vr_arb_pkg;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_e;

  // Wrap increment that works for any requester count, not only powers of two.
  function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/vr_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr_i,
// wrapping explicitly at NUM_REQ.
module rr_pick
  import vr_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic               any_o,
  output logic [IDX_W-1:0]   winner_o,
  output logic [NUM_REQ-1:0] grant_o
);

  always_comb begin
    int unsigned idx;
    idx      = 0;
    any_o    = 1'b0;
    winner_o = '0;
    grant_o  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = 32'(ptr_i) + 32'(k);
      if (idx >= 32'(NUM_REQ)) idx = idx - 32'(NUM_REQ);
      if (!any_o && req_i[IDX_W'(idx)]) begin
        any_o    = 1'b1;
        winner_o = IDX_W'(idx);
      end
    end
    if (any_o) grant_o[winner_o] = 1'b1;
  end

endmodule

// File: rtl/vr_rr_arbiter.sv
// N-to-1 round-robin valid/ready arbiter with a single registered output stage.
// Optional packet locking on last_up_in is enabled by defining VR_ARB_LAST_LOCK_EN.
module vr_rr_arbiter
  import vr_arb_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ*WIDTH-1:0] data_in,
  input  logic [NUM_REQ-1:0]       valid_up_in,
  output logic [NUM_REQ-1:0]       ready_up_out,
`ifdef VR_ARB_LAST_LOCK_EN
  input  logic [NUM_REQ-1:0]       last_up_in,
  output logic                     last_down_out,
`endif
  output logic [WIDTH-1:0]         data_out,
  output logic                     valid_down_out,
  input  logic                     ready_down_in,
  output logic [IDX_W-1:0]         grant_id_out
);

  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic               valid_q, valid_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [IDX_W-1:0]   gid_q, gid_d;

  logic [NUM_REQ-1:0] req_eff;
  logic               pick_any;
  logic [IDX_W-1:0]   winner;
  logic [NUM_REQ-1:0] pick_gnt;
  logic               can_load, up_fire, down_fire, adv_ptr;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req_i    (req_eff),
    .ptr_i    (ptr_q),
    .any_o    (pick_any),
    .winner_o (winner),
    .grant_o  (pick_gnt)
  );

  assign can_load     = ~valid_q | ready_down_in;
  assign down_fire    = valid_q & ready_down_in;
  assign ready_up_out = (can_load & pick_any) ? pick_gnt : '0;
  assign up_fire      = |(ready_up_out & valid_up_in);

`ifdef VR_ARB_LAST_LOCK_EN
  lock_state_e      state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic             last_q;

  // While locked only the owner may compete; an absent owner yields no grant.
  always_comb begin
    req_eff = valid_up_in;
    if (state_q == LOCKED) begin
      req_eff          = '0;
      req_eff[owner_q] = valid_up_in[owner_q];
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    case (state_q)
      UNLOCKED: if (up_fire && !last_up_in[winner]) begin
        state_d = LOCKED;
        owner_d = winner;
      end
      LOCKED:   if (up_fire && last_up_in[owner_q]) state_d = UNLOCKED;
      default:  state_d = UNLOCKED;
    endcase
  end

  // Fairness only moves when a packet completes.
  assign adv_ptr = up_fire & last_up_in[winner];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= UNLOCKED;
      owner_q <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      if (up_fire) last_q <= last_up_in[winner];
    end
  end

  assign last_down_out = last_q;
`else
  assign req_eff = valid_up_in;
  assign adv_ptr = up_fire;
`endif

  // A new beat replaces a draining one on the same edge, so no bubble appears.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    gid_d   = gid_q;
    ptr_d   = ptr_q;
    if (up_fire) begin
      valid_d = 1'b1;
      data_d  = data_in[winner*WIDTH +: WIDTH];
      gid_d   = winner;
    end else if (down_fire) begin
      valid_d = 1'b0;
    end
    if (adv_ptr) ptr_d = IDX_W'(next_idx(32'(winner), NUM_REQ));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      gid_q   <= '0;
      ptr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      gid_q   <= gid_d;
      ptr_q   <= ptr_d;
    end
  end

  assign data_out       = data_q;
  assign valid_down_out = valid_q;
  assign grant_id_out   = gid_q;

endmodule

// File: tb/tb_vr_rr_arbiter.sv
// Table-driven bench with a beat scoreboard for vr_rr_arbiter (NUM_REQ=4 and NUM_REQ=3).
module tb_vr_rr_arbiter;

  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [4*W-1:0] data_up;
  logic [3:0]    valid_up, ready_up;
  logic [W-1:0]  data_dn;
  logic          valid_dn, rdy_dn;
  logic [1:0]    gid;

  logic [3*W-1:0] data_up3;
  logic [2:0]    valid3, ready3;
  logic [W-1:0]  data3;
  logic          vld3, rdy_dn3;
  logic [1:0]    gid3;

`ifdef VR_ARB_LAST_LOCK_EN
  logic [3:0] last_up;
  logic       last_dn;
  logic       last_dn3;
`endif

  vr_rr_arbiter #(.WIDTH(W), .NUM_REQ(4)) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .data_in        (data_up),
    .valid_up_in    (valid_up),
    .ready_up_out   (ready_up),
`ifdef VR_ARB_LAST_LOCK_EN
    .last_up_in     (last_up),
    .last_down_out  (last_dn),
`endif
    .data_out       (data_dn),
    .valid_down_out (valid_dn),
    .ready_down_in  (rdy_dn),
    .grant_id_out   (gid)
  );

  vr_rr_arbiter #(.WIDTH(W), .NUM_REQ(3)) u_dut3 (
    .clk            (clk),
    .rst_n          (rst_n),
    .data_in        (data_up3),
    .valid_up_in    (valid3),
    .ready_up_out   (ready3),
`ifdef VR_ARB_LAST_LOCK_EN
    .last_up_in     (3'b111),
    .last_down_out  (last_dn3),
`endif
    .data_out       (data3),
    .valid_down_out (vld3),
    .ready_down_in  (rdy_dn3),
    .grant_id_out   (gid3)
  );

  typedef struct packed {
    logic [3:0] v;   // valid_up_in
    logic       r;   // ready_down_in
    logic [3:0] er;  // expected ready_up_out
    logic       ev;  // expected valid_down_out before the edge
  } vec_t;

  typedef struct packed {
    logic [1:0]   id;
    logic [W-1:0] data;
  } beat_t;

  vec_t  tbl [33];
  beat_t sb [$];

  int n_cmp  = 0;
  int n_fail = 0;

  logic         stalled_prev = 1'b0;
  logic [W-1:0] prev_data;
  logic [1:0]   prev_gid;

  task automatic chk(input string nm, input int tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s tag=%0d actual=0x%0h required=0x%0h", nm, tag, act, exp);
    end
  endtask

  function automatic logic [W-1:0] pay(input int tag, input int i);
    return 32'(tag * 256 + 'hA0 + i);
  endfunction

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n    = 1'b0;
    valid_up = '0;
    valid3   = '0;
    rdy_dn   = 1'b1;
    rdy_dn3  = 1'b1;
    #1;
    chk("rst_data",  0, data_dn, 0);
    chk("rst_valid", 0, 32'(valid_dn), 0);
    chk("rst_gid",   0, 32'(gid), 0);
    chk("rst_ready", 0, 32'(ready_up), 0);
    chk("rst3_valid", 0, 32'(vld3), 0);
    chk("rst3_ready", 0, 32'(ready3), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb.delete();
    stalled_prev = 1'b0;
  endtask

  // One clock: drive after the edge, check mid-cycle, pop drained beat, push accepted beat.
  task automatic cycle(input vec_t t, input int tag);
    beat_t b;
    @(posedge clk);
    #1;
    valid_up = t.v;
    rdy_dn   = t.r;
    for (int i = 0; i < 4; i++) data_up[i*W +: W] = pay(tag, i);
    @(negedge clk);
    chk("ready_up", tag, 32'(ready_up), 32'(t.er));
    chk("valid_dn", tag, 32'(valid_dn), 32'(t.ev));
    if (stalled_prev) begin
      chk("stall_data", tag, data_dn, prev_data);
      chk("stall_gid",  tag, 32'(gid), 32'(prev_gid));
    end
    stalled_prev = valid_dn & ~rdy_dn;
    prev_data    = data_dn;
    prev_gid     = gid;
    if (valid_dn && rdy_dn) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", tag, 32'(1), 32'(0));
      end else begin
        b = sb.pop_front();
        chk("beat_gid",  tag, 32'(gid), 32'(b.id));
        chk("beat_data", tag, data_dn, b.data);
      end
    end
    if (t.er != 4'b0000) begin
      b = '0;
      for (int i = 0; i < 4; i++) if (t.er[i]) b.id = 2'(i);
      b.data = pay(tag, int'(b.id));
      sb.push_back(b);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    data_up  = '0;
    valid_up = '0;
    rdy_dn   = 1'b1;
    data_up3 = '0;
    valid3   = '0;
    rdy_dn3  = 1'b1;
`ifdef VR_ARB_LAST_LOCK_EN
    last_up  = 4'hF;
`endif
    for (int i = 0; i < 3; i++) data_up3[i*W +: W] = 32'('hA0 + i);

    // v, r, expected ready, expected valid_down
    for (int i = 0; i < 10; i++) tbl[i] = {4'b0000, 1'b1, 4'b0000, 1'b0};
    tbl[10] = {4'b1111, 1'b1, 4'b0001, 1'b0};
    tbl[11] = {4'b1111, 1'b1, 4'b0010, 1'b1};
    tbl[12] = {4'b1111, 1'b1, 4'b0100, 1'b1};
    tbl[13] = {4'b1111, 1'b1, 4'b1000, 1'b1};
    tbl[14] = {4'b1111, 1'b1, 4'b0001, 1'b1};
    tbl[15] = {4'b1111, 1'b1, 4'b0010, 1'b1};
    tbl[16] = {4'b1010, 1'b1, 4'b1000, 1'b1};
    tbl[17] = {4'b1010, 1'b1, 4'b0010, 1'b1};
    tbl[18] = {4'b1010, 1'b1, 4'b1000, 1'b1};
    tbl[19] = {4'b0000, 1'b1, 4'b0000, 1'b1};
    tbl[20] = {4'b0000, 1'b1, 4'b0000, 1'b0};
    tbl[21] = {4'b1111, 1'b1, 4'b0001, 1'b0};
    for (int i = 22; i < 27; i++) tbl[i] = {4'b1111, 1'b0, 4'b0000, 1'b1};
    tbl[27] = {4'b1111, 1'b1, 4'b0010, 1'b1};
    tbl[28] = {4'b0100, 1'b0, 4'b0000, 1'b1};
    tbl[29] = {4'b0100, 1'b1, 4'b0100, 1'b1};
    tbl[30] = {4'b0001, 1'b1, 4'b0001, 1'b1};
    tbl[31] = {4'b0000, 1'b0, 4'b0000, 1'b1};
    tbl[32] = {4'b0000, 1'b1, 4'b0000, 1'b1};

    do_reset();
    for (int i = 0; i < 33; i++) cycle(tbl[i], i);
    chk("sb_drained", 33, 32'(sb.size()), 0);

    // Non-power-of-two requester count: grants must wrap 2 -> 0.
    for (int k = 0; k < 7; k++) begin
      @(posedge clk);
      #1;
      valid_up = '0;
      valid3   = 3'b111;
      rdy_dn3  = 1'b1;
      @(negedge clk);
      chk("n3_ready", 200 + k, 32'(ready3), 32'(1 << (k % 3)));
      if (k > 0) begin
        chk("n3_valid", 200 + k, 32'(vld3), 1);
        chk("n3_gid",   200 + k, 32'(gid3), 32'((k - 1) % 3));
        chk("n3_data",  200 + k, data3, 32'('hA0 + (k - 1) % 3));
      end
    end
    valid3 = '0;

`ifdef VR_ARB_LAST_LOCK_EN
    do_reset();
    last_up = 4'b0000; cycle({4'b0011, 1'b1, 4'b0001, 1'b0}, 100);
    last_up = 4'b0000; cycle({4'b0011, 1'b1, 4'b0001, 1'b1}, 101);
    last_up = 4'b0001; cycle({4'b0011, 1'b1, 4'b0001, 1'b1}, 102);
    last_up = 4'b0011; cycle({4'b0011, 1'b1, 4'b0010, 1'b1}, 103);
    last_up = 4'b0000; cycle({4'b0011, 1'b1, 4'b0001, 1'b1}, 104);
    last_up = 4'b0000; cycle({4'b0010, 1'b1, 4'b0000, 1'b1}, 105);
    do_reset();
    last_up = 4'b0000; cycle({4'b1010, 1'b1, 4'b0010, 1'b0}, 106);
    last_up = 4'hF;    cycle({4'b0000, 1'b1, 4'b0000, 1'b1}, 107);
    chk("lock_sb_drained", 108, 32'(sb.size()), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
